// File: rtl/max_pool_1d_stream_if.sv
// max_pool_1d_stream_if
//   Bundles the streaming handshake of max_pool_1d_stream: the input sample
//   channel (valid_in/ready_in/input_data/last_in), the output channel
//   (valid_out/ready_out/output_data/last_out/idx_out) and the tail_drop pulse.
//   Modports:
//     slave  - pooling block view (consumes samples, produces window maxima)
//     master - surrounding pipeline view (produces samples, consumes maxima)
//   Build option: MAX_POOL_ARGMAX_EN adds the IDX_W parameter and idx_out.
interface max_pool_1d_stream_if #(
  parameter int DATA_W = 32
`ifdef MAX_POOL_ARGMAX_EN
  , parameter int IDX_W = 16
`endif
);
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] input_data;
  logic              last_in;
  logic              valid_out;
  logic              ready_out;
  logic [DATA_W-1:0] output_data;
  logic              last_out;
  logic              tail_drop;
`ifdef MAX_POOL_ARGMAX_EN
  logic [IDX_W-1:0]  idx_out;
`endif

  modport slave (
    input  valid_in, input_data, last_in, ready_out,
    output ready_in, valid_out, output_data, last_out, tail_drop
`ifdef MAX_POOL_ARGMAX_EN
    , output idx_out
`endif
  );

  modport master (
    output valid_in, input_data, last_in, ready_out,
    input  ready_in, valid_out, output_data, last_out, tail_drop
`ifdef MAX_POOL_ARGMAX_EN
    , input idx_out
`endif
  );
endinterface

// File: rtl/max_pool_1d_stream.sv
// max_pool_1d_stream
//   Streaming 1-D max pooling over framed sequences (window KERNEL, step
//   STRIDE, no padding). One sample per cycle in, one maximum per completed
//   window out, with a single registered output stage and backpressure.
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset
//     bus    - max_pool_1d_stream_if.slave: valid_in/ready_in/input_data/
//              last_in in, valid_out/ready_out/output_data/last_out out,
//              tail_drop pulse, idx_out (argmax build only)
//   Build option: define MAX_POOL_ARGMAX_EN to keep a position per window slot
//   and report the in-sequence position of the selected maximum on idx_out.
module max_pool_1d_stream #(
  parameter int DATA_W = 32,
  parameter int KERNEL = 4,
  parameter int STRIDE = 2,
  parameter int SIGNED = 1,
  parameter int IDX_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  max_pool_1d_stream_if.slave bus
);

  // The incoming sample is the newest window member, so only KERNEL-1
  // previous samples need storage.
  localparam int DEPTH  = (KERNEL > 1) ? KERNEL - 1 : 1;
  localparam int FILL_W = $clog2(KERNEL + 1);
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  function automatic logic greater(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) return sa > sb;
    else             return a > b;
  endfunction

  logic [DATA_W-1:0] win_p0 [DEPTH];
`ifdef MAX_POOL_ARGMAX_EN
  logic [IDX_W-1:0]  wpos_p0 [DEPTH];
  logic [IDX_W-1:0]  best_idx_p0;
  logic [IDX_W-1:0]  idx_p1;
`endif
  logic [FILL_W-1:0] fill_p0;
  logic [PH_W-1:0]   phase_p0;
  logic [IDX_W-1:0]  pos_p0;

  logic              accept_p0;
  logic              eligible_p0;
  logic              complete_p0;
  logic [DATA_W-1:0] best_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic              tail_p1;

  // ---- stage p0: accept, window scan, completion decision ----
  assign bus.ready_in = !vld_p1 || bus.ready_out;
  assign accept_p0    = bus.valid_in && bus.ready_in;
  assign eligible_p0  = fill_p0 >= FILL_W'(KERNEL - 1);
  assign complete_p0  = eligible_p0 && (phase_p0 == '0);

  // Scan newest to oldest; an older sample replaces the current best on a
  // tie, so ties resolve to the earliest position.
  always_comb begin
    best_p0 = bus.input_data;
`ifdef MAX_POOL_ARGMAX_EN
    best_idx_p0 = pos_p0;
`endif
    for (int i = 0; i < KERNEL - 1; i++) begin
      if (!greater(best_p0, win_p0[i])) begin
        best_p0 = win_p0[i];
`ifdef MAX_POOL_ARGMAX_EN
        best_idx_p0 = wpos_p0[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      win_p0[0] <= bus.input_data;
      for (int i = 1; i < DEPTH; i++) win_p0[i] <= win_p0[i-1];
`ifdef MAX_POOL_ARGMAX_EN
      wpos_p0[0] <= pos_p0;
      for (int i = 1; i < DEPTH; i++) wpos_p0[i] <= wpos_p0[i-1];
`endif
    end
  end

  // ---- stage p1: output register, framing counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_p0  <= '0;
      phase_p0 <= '0;
      pos_p0   <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
      tail_p1  <= 1'b0;
`ifdef MAX_POOL_ARGMAX_EN
      idx_p1   <= '0;
`endif
    end else begin
      tail_p1 <= accept_p0 && bus.last_in && !complete_p0;

      // A new result can only load when ready_in was high, i.e. the held
      // result (if any) is leaving in this same cycle.
      if (accept_p0 && complete_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= best_p0;
        last_p1 <= bus.last_in;
`ifdef MAX_POOL_ARGMAX_EN
        idx_p1  <= best_idx_p0;
`endif
      end else if (bus.ready_out) begin
        vld_p1 <= 1'b0;
      end

      if (accept_p0) begin
        if (bus.last_in) begin
          fill_p0  <= '0;
          phase_p0 <= '0;
          pos_p0   <= '0;
        end else begin
          if (fill_p0 != FILL_W'(KERNEL)) fill_p0 <= fill_p0 + 1'b1;
          // Phase only advances once windows can complete; it marks the
          // stride offset without needing a modulo.
          if (eligible_p0)
            phase_p0 <= (phase_p0 == PH_W'(STRIDE - 1)) ? '0 : phase_p0 + 1'b1;
          pos_p0 <= pos_p0 + 1'b1;
        end
      end
    end
  end

  assign bus.valid_out   = vld_p1;
  assign bus.output_data = data_p1;
  assign bus.last_out    = last_p1;
  assign bus.tail_drop   = tail_p1;
`ifdef MAX_POOL_ARGMAX_EN
  assign bus.idx_out     = idx_p1;
`endif

endmodule
